axi_interconnect_crossbar_bresp_route: RTL and testbench
========================================================

Name: axi_interconnect_crossbar_bresp_route

Overview:
- Write-response return path for one slave port of the crossbar.
- Records the master index the round-robin arbiter granted on each accepted AW burst in an in-order tracking FIFO.
- Steers each B response from the slave back to that master, one response per recorded grant, in order.
- Forms the responder-side counterpart of the AW grant path.

Parameters:
- NUM, 4: number of master ports.
- WIDTH, LOG2(NUM-1) (minimum 1): master index width, same definition as the arbiter's.
- ID_W, 4: BID width.
- DEPTH, 8: maximum outstanding write bursts per slave port; power of two, ≥2.
- CW, LOG2(DEPTH)+1: outstanding counter width.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- aw_push  in  1  AW handshake completed on slave side (awvalid&awready) this cycle.
- aw_user  in  WIDTH  granted master index for that AW.
- aw_full  out  1  tracking FIFO full; arbiter must not grant AW while high.
- s_bvalid  in  1  slave B valid.
- s_bready  out  1  slave B ready.
- s_bid  in  ID_W  slave BID.
- s_bresp  in  2  slave BRESP.
- m_bvalid  out  NUM  per-master B valid, one-hot or zero.
- m_bready  in  NUM  per-master B ready.
- m_bid  out  ID_W  BID, broadcast to all masters.
- m_bresp  out  2  BRESP, broadcast to all masters.
- outstanding  out  CW  bursts pushed and not yet popped.
- err  out  2  sticky error flags; bit0 push while full, bit1 aw_user ≥ NUM.

Behaviour:
- Reset (aresetn low, asynchronous) clears:
  - FIFO pointers; outstanding=0, aw_full=0.
  - Output register empty: m_bvalid=0, m_bid=0, m_bresp=0.
  - err=0, s_bready=0.
- Reset mid-operation discards all tracked bursts and any held response. No B is emitted after release until new pushes occur.
- Tracking FIFO:
  - Push on aw_push when count<DEPTH and aw_user<NUM.
  - aw_push at count==DEPTH: ignored, err[0] set. This holds even if a pop occurs the same cycle.
  - aw_user≥NUM: ignored, err[1] set.
  - aw_full = (outstanding==DEPTH), registered, from count only.
  - Simultaneous push and pop leave outstanding unchanged.
  - Pointers wrap modulo DEPTH.
- No fall-through: a push in cycle N is visible as the FIFO head in cycle N+1. s_bready stays 0 while the FIFO is empty, and a B arriving with no tracked burst stalls.
- Output register, one entry: out_v, out_dst, out_id, out_resp.
  - m_bvalid = out_v ? (1<<out_dst) : 0.
  - m_bid = out_id, m_bresp = out_resp.
  - Both hold stable while m_bvalid is high and not accepted (AXI rule).
- s_bready = fifo_nonempty & (~out_v | m_bready[out_dst]). Combinational from registered state and m_bready; no dependency on s_bvalid.
- Capture on s_bvalid&s_bready:
  - out_v←1, out_dst←FIFO head, out_id←s_bid, out_resp←s_bresp.
  - FIFO pops.
- Release: out_v&m_bready[out_dst] without a capture the same cycle sets out_v←0.
- Latency and throughput: capture cycle N gives m_bvalid in cycle N+1. Sustained throughput is 1 response/cycle when the destination is ready.
- m_bready of non-destination masters is ignored.
- BRESP values are passed through unmodified. DECERR generation is not done here.

Decomposition:
- Shared package axi_interconnect_pkg:
  - LOG2 function.
  - BRESP constants OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
  - err bit index constants.
- Sub-module axi_interconnect_crossbar_order_fifo:
  - Synchronous FIFO, parameters DATA_W=WIDTH and DEPTH.
  - Ports: push, pop, din, dout(head), count, full, empty.
  - Reused later by the R-channel return path.

Test Plan:
- Reset and order, NUM=4: push users 2,0,3 → s_bvalid bursts with BID 5,6,7 and BRESP OKAY. Required: m_bvalid=4'b0100 (bid 5), then 4'b0001 (bid 6), then 4'b1000 (bid 7), each one cycle after its capture; outstanding goes 3→0.
- Backpressure: push user 1; slave B bid=3, resp=SLVERR; hold m_bready[1]=0 for 5 cycles, with m_bready[0]=1 throughout. Required: m_bvalid=4'b0010 and m_bid/m_bresp stable for 5 cycles; second B stalled (s_bready=0); release on the first cycle with m_bready[1]=1.
- Full: 8 pushes without B → aw_full=1, outstanding=8. 9th push: err=2'b01, outstanding stays 8. One B popped → aw_full=0 next cycle.
- Simultaneous push and pop at outstanding=4 for 10 cycles with round-robin users 0..3. Required: outstanding stays 4, destination order preserved, pointers wrap with no loss.
- Unexpected B with empty FIFO: s_bvalid=1 → s_bready=0 and m_bvalid=0 indefinitely. Then push user 3; the B is accepted 1 cycle after the push and m_bvalid=4'b1000 the cycle after that.
- Invalid user and mid-op reset:
  - Push aw_user=... omitted: NUM=3, WIDTH=2; push aw_user=3 → err[1] set, not tracked.
  - Assert aresetn low while m_bvalid is high → m_bvalid=0 and outstanding=0 immediately (asynchronous), err=0.

Source files
------------

// File: rtl/axi_interconnect_pkg.sv
// Shared crossbar definitions: width helper, BRESP encodings and error-flag bit positions.
package axi_interconnect_pkg;

    // Number of bits needed to hold value (at least 1).
    function automatic int LOG2(input int value);
        int bits;
        bits = 1;
        while ((value >> bits) != 0) bits++;
        return bits;
    endfunction

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    localparam int ERR_PUSH_FULL = 0;
    localparam int ERR_BAD_USER  = 1;

endpackage

// File: rtl/axi_interconnect_crossbar_order_fifo.sv
// In-order tracking FIFO with registered count/full/empty; no fall-through from push to head.
module axi_interconnect_crossbar_order_fifo
    import axi_interconnect_pkg::*;
#(
    parameter int DATA_W = 2,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = LOG2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = DEPTH[CNT_W-1:0];

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;
    logic [CNT_W-1:0]  count_nxt;

    // Full is judged on the registered count, so a same-cycle pop never frees room for a push.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        count_nxt = count;
        if (do_push && !do_pop) begin
            count_nxt = count + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_nxt = count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_nxt;
            full  <= (count_nxt == DEPTH_CNT);
            empty <= (count_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/axi_interconnect_crossbar_bresp_route.sv
// B-channel return path for one slave port: steers each write response to the master
// whose AW was granted, in grant order, through a single-entry output register.
module axi_interconnect_crossbar_bresp_route
    import axi_interconnect_pkg::*;
#(
    parameter int NUM   = 4,
    parameter int WIDTH = (LOG2(NUM - 1) < 1) ? 1 : LOG2(NUM - 1),
    parameter int ID_W  = 4,
    parameter int DEPTH = 8,
    parameter int CW    = LOG2(DEPTH) + 1
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             aw_push,
    input  logic [WIDTH-1:0] aw_user,
    output logic             aw_full,
    input  logic             s_bvalid,
    output logic             s_bready,
    input  logic [ID_W-1:0]  s_bid,
    input  logic [1:0]       s_bresp,
    output logic [NUM-1:0]   m_bvalid,
    input  logic [NUM-1:0]   m_bready,
    output logic [ID_W-1:0]  m_bid,
    output logic [1:0]       m_bresp,
    output logic [CW-1:0]    outstanding,
    output logic [1:0]       err
);

    localparam logic [WIDTH:0]   USER_LIMIT = NUM[WIDTH:0];
    localparam logic [NUM-1:0]   ONE_HOT0   = {{(NUM-1){1'b0}}, 1'b1};

    logic             user_ok;
    logic             fifo_push;
    logic             fifo_full;
    logic             fifo_empty;
    logic [WIDTH-1:0] head_dst;
    logic             capture;

    logic             out_v;
    logic [WIDTH-1:0] out_dst;
    logic [ID_W-1:0]  out_id;
    logic [1:0]       out_resp;

    assign user_ok   = ({1'b0, aw_user} < USER_LIMIT);
    assign fifo_push = aw_push & user_ok & ~fifo_full;

    axi_interconnect_crossbar_order_fifo #(
        .DATA_W (WIDTH),
        .DEPTH  (DEPTH),
        .CNT_W  (CW)
    ) u_order_fifo (
        .clk   (aclk),
        .rst_n (aresetn),
        .push  (fifo_push),
        .pop   (capture),
        .din   (aw_user),
        .dout  (head_dst),
        .count (outstanding),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign aw_full = fifo_full;

    // Ready never looks at s_bvalid; a B with nothing tracked simply waits.
    assign s_bready = ~fifo_empty & (~out_v | m_bready[out_dst]);
    assign capture  = s_bvalid & s_bready;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            out_v    <= 1'b0;
            out_dst  <= '0;
            out_id   <= '0;
            out_resp <= '0;
            err      <= '0;
        end else begin
            if (capture) begin
                out_v    <= 1'b1;
                out_dst  <= head_dst;
                out_id   <= s_bid;
                out_resp <= s_bresp;
            end else if (out_v && m_bready[out_dst]) begin
                out_v <= 1'b0;
            end
            if (aw_push && fifo_full) err[ERR_PUSH_FULL] <= 1'b1;
            if (aw_push && !user_ok)  err[ERR_BAD_USER]  <= 1'b1;
        end
    end

    assign m_bvalid = out_v ? (ONE_HOT0 << out_dst) : '0;
    assign m_bid    = out_id;
    assign m_bresp  = out_resp;

endmodule

// File: tb/tb_axi_interconnect_crossbar_bresp_route.sv
// Randomised and directed checks of the B return path against a queue-based model and scoreboard.
module tb_axi_interconnect_crossbar_bresp_route;
    import axi_interconnect_pkg::*;

    localparam int NUM   = 4;
    localparam int WIDTH = 2;
    localparam int ID_W  = 4;
    localparam int DEPTH = 8;
    localparam int CW    = 5;

    typedef struct { int dst; int id; int resp; } rsp_t;

    logic             aclk = 1'b0;
    logic             aresetn;
    logic             aw_push;
    logic [WIDTH-1:0] aw_user;
    logic             aw_full;
    logic             s_bvalid;
    logic             s_bready;
    logic [ID_W-1:0]  s_bid;
    logic [1:0]       s_bresp;
    logic [NUM-1:0]   m_bvalid;
    logic [NUM-1:0]   m_bready;
    logic [ID_W-1:0]  m_bid;
    logic [1:0]       m_bresp;
    logic [CW-1:0]    outstanding;
    logic [1:0]       err;

    logic             t3_aw_push;
    logic [1:0]       t3_aw_user;
    logic             t3_aw_full;
    logic             t3_s_bready;
    logic [2:0]       t3_m_bvalid;
    logic [ID_W-1:0]  t3_m_bid;
    logic [1:0]       t3_m_bresp;
    logic [CW-1:0]    t3_outstanding;
    logic [1:0]       t3_err;

    int n_chk  = 0;
    int n_fail = 0;

    int   dst_q[$];
    rsp_t exp_q[$];
    bit   mo_v;
    int   mo_dst;
    logic [1:0] exp_err;
    bit   acc, cap_prev, prev_stall;
    rsp_t cap_last;
    logic [ID_W-1:0] prev_bid;
    logic [1:0]      prev_bresp;

    always #5 aclk = ~aclk;

    axi_interconnect_crossbar_bresp_route #(
        .NUM(NUM), .ID_W(ID_W), .DEPTH(DEPTH)
    ) u_dut (
        .aclk(aclk), .aresetn(aresetn), .aw_push(aw_push), .aw_user(aw_user), .aw_full(aw_full),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid), .s_bresp(s_bresp),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bid(m_bid), .m_bresp(m_bresp),
        .outstanding(outstanding), .err(err)
    );

    axi_interconnect_crossbar_bresp_route #(
        .NUM(3), .ID_W(ID_W), .DEPTH(DEPTH)
    ) u_dut3 (
        .aclk(aclk), .aresetn(aresetn), .aw_push(t3_aw_push), .aw_user(t3_aw_user), .aw_full(t3_aw_full),
        .s_bvalid(1'b0), .s_bready(t3_s_bready), .s_bid('0), .s_bresp(2'b00),
        .m_bvalid(t3_m_bvalid), .m_bready(3'b111), .m_bid(t3_m_bid), .m_bresp(t3_m_bresp),
        .outstanding(t3_outstanding), .err(t3_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Model: dst_q holds granted masters in order; exp_q holds responses owed to masters.
    always @(negedge aclk) begin
        bit   exp_sr, cap, rel;
        int   sz0, d;
        rsp_t r;
        if (!aresetn) begin
            dst_q.delete();
            exp_q.delete();
            mo_v = 0; exp_err = 2'b00; acc = 0; cap_prev = 0; prev_stall = 0;
        end else begin
            sz0 = dst_q.size();
            chk("outstanding", outstanding, sz0);
            chk("aw_full", aw_full, sz0 == DEPTH);
            chk("err", err, exp_err);
            exp_sr = (sz0 > 0) && (!mo_v || m_bready[mo_dst]);
            chk("s_bready", s_bready, exp_sr);
            chk("m_bvalid", m_bvalid, mo_v ? (1 << mo_dst) : 0);
            if (cap_prev) begin
                chk("cap_bid", m_bid, cap_last.id);
                chk("cap_bresp", m_bresp, cap_last.resp);
            end
            if (prev_stall) begin
                chk("hold_bid", m_bid, prev_bid);
                chk("hold_bresp", m_bresp, prev_bresp);
            end
            if ((m_bvalid & m_bready) != 0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_resp", m_bvalid, 0);
                end else begin
                    r = exp_q.pop_front();
                    chk("sb_dst", m_bvalid, 1 << r.dst);
                    chk("sb_bid", m_bid, r.id);
                    chk("sb_bresp", m_bresp, r.resp);
                end
            end
            cap = s_bvalid && exp_sr;
            rel = mo_v && m_bready[mo_dst];
            prev_stall = mo_v && !m_bready[mo_dst];
            prev_bid   = m_bid;
            prev_bresp = m_bresp;
            if (cap) begin
                d = dst_q.pop_front();
                cap_last = '{d, int'(s_bid), int'(s_bresp)};
                exp_q.push_back(cap_last);
                mo_v = 1;
                mo_dst = d;
            end else if (rel) begin
                mo_v = 0;
            end
            cap_prev = cap;
            if (aw_push) begin
                if (sz0 == DEPTH) exp_err[0] = 1'b1;
                if (int'(aw_user) >= NUM) exp_err[1] = 1'b1;
                if (sz0 < DEPTH && int'(aw_user) < NUM) dst_q.push_back(int'(aw_user));
            end
            acc = s_bvalid && s_bready;
        end
    end

    task automatic drain();
        int n;
        n = 0;
        aw_push = 1'b0;
        while ((outstanding != 0 || m_bvalid != 0) && n < 300) begin
            if (!s_bvalid || acc) begin
                s_bvalid = 1'b1;
                s_bid    = ID_W'($urandom);
                s_bresp  = 2'($urandom);
            end
            m_bready = NUM'($urandom);
            tick();
            n++;
        end
        chk("drain_done", {outstanding, m_bvalid}, 0);
        s_bvalid = 1'b0;
        m_bready = '1;
        tick();
    endtask

    task automatic rand_phase(input int cycles, input int pp, input int bp);
        for (int i = 0; i < cycles; i++) begin
            aw_push = ($urandom_range(99) < pp);
            aw_user = WIDTH'($urandom_range(NUM - 1));
            if (!s_bvalid || acc) begin
                s_bvalid = ($urandom_range(99) < bp);
                s_bid    = ID_W'($urandom);
                s_bresp  = 2'($urandom);
            end
            m_bready = NUM'($urandom);
            tick();
        end
        aw_push = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int order_dst[3];
        aresetn = 1'b0;
        aw_push = 1'b0; aw_user = '0;
        s_bvalid = 1'b0; s_bid = '0; s_bresp = OKAY;
        m_bready = '1;
        t3_aw_push = 1'b0; t3_aw_user = '0;
        order_dst[0] = 2; order_dst[1] = 0; order_dst[2] = 3;

        @(negedge aclk);
        chk("rst_m_bvalid", m_bvalid, 0);
        chk("rst_s_bready", s_bready, 0);
        chk("rst_aw_full", aw_full, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_err", err, 0);
        chk("rst_bid_bresp", {m_bid, m_bresp}, 0);
        tick();
        aresetn = 1'b1;
        tick();

        // in-order steering
        for (int k = 0; k < 3; k++) begin
            aw_push = 1'b1; aw_user = WIDTH'(order_dst[k]);
            tick();
        end
        aw_push = 1'b0;
        @(negedge aclk);
        chk("order_outstanding3", outstanding, 3);
        tick();
        s_bvalid = 1'b1; s_bid = 4'd5; s_bresp = OKAY;
        tick();
        for (int k = 0; k < 3; k++) begin
            if (k < 2) s_bid = ID_W'(6 + k);
            else s_bvalid = 1'b0;
            @(negedge aclk);
            chk("order_dst", m_bvalid, 1 << order_dst[k]);
            chk("order_bid", m_bid, 5 + k);
            tick();
        end
        @(negedge aclk);
        chk("order_outstanding0", outstanding, 0);
        tick();

        // backpressure on master 1
        m_bready = 4'b0001;
        aw_push = 1'b1; aw_user = 2'd1; tick();
        aw_user = 2'd2; tick();
        aw_push = 1'b0;
        s_bvalid = 1'b1; s_bid = 4'd3; s_bresp = SLVERR;
        tick();
        s_bid = 4'd4; s_bresp = OKAY;
        repeat (5) begin
            @(negedge aclk);
            chk("bp_mbv", m_bvalid, 4'b0010);
            chk("bp_bid", m_bid, 3);
            chk("bp_bresp", m_bresp, SLVERR);
            chk("bp_stall", s_bready, 0);
            tick();
        end
        m_bready = 4'b0011;
        @(negedge aclk);
        chk("bp_release", s_bready, 1);
        tick();
        s_bvalid = 1'b0;
        @(negedge aclk);
        chk("bp_next_mbv", m_bvalid, 4'b0100);
        chk("bp_next_bid", m_bid, 4);
        m_bready = '1;
        drain();

        // fill to depth and overflow
        for (int k = 0; k < DEPTH; k++) begin
            aw_push = 1'b1; aw_user = WIDTH'($urandom_range(NUM - 1));
            tick();
        end
        aw_push = 1'b0;
        @(negedge aclk);
        chk("full_flag", aw_full, 1);
        chk("full_count", outstanding, 8);
        chk("full_err_clear", err, 0);
        tick();
        aw_push = 1'b1;
        tick();
        aw_push = 1'b0;
        @(negedge aclk);
        chk("ovf_err", err, 2'b01);
        chk("ovf_count", outstanding, 8);
        tick();
        s_bvalid = 1'b1; s_bid = 4'd1;
        tick();
        s_bvalid = 1'b0;
        @(negedge aclk);
        chk("unfull_flag", aw_full, 0);
        chk("unfull_count", outstanding, 7);
        drain();

        // steady push+pop at depth 4
        for (int k = 0; k < 4; k++) begin
            aw_push = 1'b1; aw_user = WIDTH'(k);
            tick();
        end
        for (int i = 0; i < 10; i++) begin
            aw_push = 1'b1; aw_user = WIDTH'(i % 4);
            s_bvalid = 1'b1; s_bid = ID_W'(i); s_bresp = OKAY;
            @(negedge aclk);
            chk("simul_count", outstanding, 4);
            if (i > 0) chk("simul_dst", m_bvalid, 1 << ((i - 1) % 4));
            tick();
        end
        aw_push = 1'b0; s_bvalid = 1'b0;
        @(negedge aclk);
        chk("simul_last_dst", m_bvalid, 4'b0010);
        chk("simul_last_bid", m_bid, 9);
        drain();

        // B with nothing tracked
        s_bvalid = 1'b1; s_bid = 4'd10; s_bresp = EXOKAY;
        repeat (6) begin
            @(negedge aclk);
            chk("orphan_sready", s_bready, 0);
            chk("orphan_mbv", m_bvalid, 0);
            tick();
        end
        aw_push = 1'b1; aw_user = 2'd3;
        @(negedge aclk);
        chk("no_fallthrough", s_bready, 0);
        tick();
        aw_push = 1'b0;
        @(negedge aclk);
        chk("orphan_accept", s_bready, 1);
        tick();
        s_bvalid = 1'b0;
        @(negedge aclk);
        chk("orphan_mbv_out", m_bvalid, 4'b1000);
        chk("orphan_bid", m_bid, 10);
        chk("orphan_bresp", m_bresp, EXOKAY);
        tick();

        rand_phase(500, 40, 50);
        drain();

        // NUM=3 instance: user 3 is out of range
        t3_aw_push = 1'b1; t3_aw_user = 2'd3; tick();
        t3_aw_user = 2'd2; tick();
        t3_aw_push = 1'b0;
        @(negedge aclk);
        chk("t3_err", t3_err, 2'b10);
        chk("t3_outstanding", t3_outstanding, 1);
        tick();

        // reset while a response is held
        m_bready = '0;
        aw_push = 1'b1; aw_user = 2'd0; tick();
        aw_user = 2'd1; tick();
        aw_push = 1'b0;
        s_bvalid = 1'b1; s_bid = 4'd7; tick();
        s_bvalid = 1'b0;
        chk("pre_rst_mbv", m_bvalid, 4'b0001);
        chk("pre_rst_count", outstanding, 1);
        aresetn = 1'b0;
        #1;
        chk("async_rst_mbv", m_bvalid, 0);
        chk("async_rst_count", outstanding, 0);
        chk("async_rst_err", err, 0);
        chk("async_rst_t3", {t3_err, t3_outstanding}, 0);
        @(negedge aclk);
        tick();
        aresetn = 1'b1;
        m_bready = '1;
        s_bvalid = 1'b1; s_bid = 4'd2;
        repeat (5) begin
            @(negedge aclk);
            chk("post_rst_mbv", m_bvalid, 0);
            chk("post_rst_sready", s_bready, 0);
            tick();
        end
        s_bvalid = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
